// File: rtl/risc_toy_pkg.sv
// ============================================================================
// risc_toy_pkg : shared defaults and helpers for the toy RISC front end
// Rev 1.0
// ============================================================================
`default_nettype none

package risc_toy_pkg;

  localparam int unsigned TOY_AW       = 30;
  localparam int unsigned TOY_DW       = 32;
  localparam int unsigned TOY_DEPTH    = 4;
  localparam int unsigned TOY_RESET_PC = 0;

  // Counter wide enough to hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_sync_fifo.sv
// ============================================================================
// risc_sync_fifo : synchronous FIFO with flush and occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module risc_sync_fifo
  import risc_toy_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i & (count_q != '0);
    do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/risc_fetch_queue.sv
// ============================================================================
// risc_fetch_queue : instruction prefetch queue with redirect flush and
//                    drop tracking of in-flight responses
// Rev 1.0
// ============================================================================
`default_nettype none

module risc_fetch_queue
  import risc_toy_pkg::*;
#(
  parameter int unsigned   AW       = TOY_AW,
  parameter int unsigned   DW       = TOY_DW,
  parameter int unsigned   DEPTH    = TOY_DEPTH,
  parameter logic [AW-1:0] RESET_PC = AW'(TOY_RESET_PC)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          REDIRECT,
  input  logic [AW-1:0] REDIRECT_ADDR,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic          IGNT,
  input  logic          IRVALID,
  input  logic [DW-1:0] IRDATA,
  output logic          D_VALID,
  output logic [DW-1:0] D_INSTR,
  output logic [31:0]   D_PCADD4,
  input  logic          D_READY,
  output logic          PROTO_ERR
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned EW = DW + AW;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] rpc_q, rpc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          proto_q, proto_d;
  logic          run_q;

  logic [CW-1:0] occ;
  logic [CW-1:0] live;
  logic [CW:0]   inflight;
  logic          accept;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [EW-1:0] head;
  logic [AW-1:0] head_pc;
  logic [29:0]   head_pc_lo;

  // Requests whose responses will be dropped no longer reserve FIFO space.
  always_comb begin
    live     = outst_q - drop_q;
    inflight = {1'b0, occ} + {1'b0, live};
    IREQ     = run_q & ~REDIRECT & (inflight < (CW+1)'(DEPTH));
    accept   = IREQ & IGNT;
    rsp_ok   = IRVALID & (outst_q != '0);
    push     = rsp_ok & ~REDIRECT & (drop_q == '0);
    pop      = ~fifo_empty & D_READY & ~REDIRECT;
  end

  always_comb begin
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    proto_d = proto_q | (IRVALID & (outst_q == '0));

    if (accept) pc_d = pc_q + AW'(1);
    case ({accept, rsp_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    if (push) rpc_d = rpc_q + AW'(1);

    // Everything still in flight after this cycle belongs to the old stream.
    if (REDIRECT) begin
      pc_d   = REDIRECT_ADDR;
      rpc_d  = REDIRECT_ADDR;
      drop_d = outst_d;
    end else if (rsp_ok && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      proto_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      proto_q <= proto_d;
      run_q   <= 1'b1;
    end
  end

  risc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RSTN),
    .flush_i (REDIRECT),
    .push_i  (push),
    .wdata_i ({IRDATA, rpc_q}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

  // Only the low 30 PC bits survive the shift into a 32-bit byte address.
  assign head_pc    = head[AW-1:0];
  assign head_pc_lo = 30'(head_pc);
  assign IADDR      = pc_q;
  assign D_VALID    = ~fifo_empty;
  assign D_INSTR    = head[EW-1:AW];
  assign D_PCADD4   = {head_pc_lo + 30'd1, 2'b00};
  assign PROTO_ERR  = proto_q;

endmodule

`default_nettype wire

// File: doc/risc_fetch_queue.md
RISC_FETCH_QUEUE -- requirements
Module: risc_fetch_queue

Interface
REQ-001 SHALL have parameter AW, default 30, meaning instruction word-address width.
REQ-002 SHALL have parameter DW, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning prefetch entries; power of two, DEPTH >= 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning word address fetched first after reset.
REQ-005 SHALL have ports, one per line:
  CLK            input   1       single clock, rising edge.
  RSTN           input   1       asynchronous, active-high reset; asserted = 1.
  REDIRECT       input   1       branch or jump taken; flush and refetch.
  REDIRECT_ADDR  input   AW      new word address.
  IREQ           output  1       fetch request valid.
  IADDR          output  AW      fetch word address.
  IGNT           input   1       memory accepts request this cycle.
  IRVALID        input   1       in-order response valid.
  IRDATA         input   DW      response instruction.
  D_VALID        output  1       head entry valid toward decode.
  D_INSTR        output  DW      head instruction.
  D_PCADD4       output  32      byte address of head + 4, i.e. (PC + 1) << 2, zero-extended or truncated to 32.
  D_READY        input   1       decode consumes head; low = FD stall.
  PROTO_ERR      output  1       sticky; IRVALID seen with nothing outstanding.

Function
REQ-006 SHALL hold fetch PC register; IADDR = PC; PC += 1 (mod 2^AW) on each accepted request (IREQ & IGNT).
REQ-007 SHALL assert IREQ iff (occupancy + live outstanding) < DEPTH and REDIRECT = 0; no request in a redirect cycle.
REQ-008 SHALL count outstanding accepted requests (width clog2(DEPTH)+1); +1 on accept, -1 on IRVALID; both in the same cycle = unchanged.
REQ-009 SHALL push IRDATA with its PC on a non-dropped IRVALID; entry readable on D_INSTR the following cycle (registered, no bypass).
REQ-010 SHALL track response PC register; set to RESET_PC or REDIRECT_ADDR; +1 per pushed response; pushed entry PC = its current value.
REQ-011 SHALL drive D_VALID = FIFO not empty; pop on D_VALID & D_READY; D_INSTR/D_PCADD4 stable while D_VALID & !D_READY.
REQ-012 SHALL allow push and pop in one cycle at any occupancy including full; occupancy unchanged.
REQ-013 SHALL, on REDIRECT: clear FIFO next cycle; set PC and response PC to REDIRECT_ADDR; load drop counter with outstanding count after this cycle's accept/response.
REQ-014 SHALL discard IRVALID while drop counter > 0, decrementing it; a response arriving in the REDIRECT cycle itself is dropped.
REQ-015 SHALL ignore D_READY in the REDIRECT cycle; no double pop; decode discards its own stage.
REQ-016 SHALL resume IREQ the cycle after REDIRECT, at REDIRECT_ADDR, even while drops are pending; live outstanding = outstanding - drop.
REQ-017 SHALL set PROTO_ERR on IRVALID with outstanding = 0, ignore that response, and clear PROTO_ERR only by reset.
REQ-018 SHALL give minimum latency: request accepted cycle t, IRVALID t+1, D_VALID t+2.

Reset
REQ-019 SHALL, on RSTN = 1, asynchronously set PC = response PC = RESET_PC, FIFO empty, outstanding = drop = 0, PROTO_ERR = 0.
REQ-020 SHALL hold IREQ = 0 and D_VALID = 0 while RSTN = 1; IREQ may rise the first edge after release.
REQ-021 SHALL drop responses to pre-reset requests only if memory is reset with the core; no tracking across reset.

Structure
REQ-022 SHALL place the default AW, DW, DEPTH and RESET_PC constants in shared package risc_toy_pkg.
REQ-023 SHALL use one sub-module, risc_sync_fifo (parametrised width and depth, count output), for the entry storage {instr, PC}; the top holds the counters.

Verification
REQ-024 SHALL cover zero-wait streaming: IGNT = 1, IRVALID one cycle after each accept, D_READY = 1 -> D_PCADD4 = 4, 8, 12... with one instruction per cycle.
REQ-025 SHALL cover backpressure: D_READY = 0 for 10 cycles, DEPTH = 4 -> IREQ falls after 4 accepts; head held stable; no entry lost on resume.
REQ-026 SHALL cover redirect with 2 outstanding: REDIRECT_ADDR = 0x100 -> 2 responses dropped; next D_PCADD4 = 0x404; IADDR = 0x100 the next cycle.
REQ-027 SHALL cover a simultaneous IRVALID and REDIRECT -> response dropped; FIFO empty the next cycle; D_VALID = 0.
REQ-028 SHALL cover a spurious IRVALID after reset -> PROTO_ERR = 1 and stays 1; FIFO stays empty.
REQ-029 SHALL cover reset mid-stream with 3 entries buffered -> D_VALID = 0 and IADDR = RESET_PC immediately, without waiting for a clock edge.
